// File: rtl/afe_iq_ser_if.sv
// Stream-side handshake bundle for afe_iq_ser.
//   in_data  : full IQ pair {Q, I}, I in the low W/2 bits
//   in_valid : in_data holds a pair
//   in_ready : sink takes in_data on this edge
// master = pair source, slave = afe_iq_ser.
interface afe_iq_ser_if #(
  parameter int W = 24
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/afe_iq_ser.sv
// AFE transmit emulator. Takes a full IQ pair per fetch, sends it over a
// half-width bus: I half (afe_sel=1), then Q half (afe_sel=0).
// This matches the interleaved format the converter presents to RX capture.
// Ports:
//   clk_2x, reset  : half-word clock, async active-high reset
//   enable         : run enable; a started pair is always finished
//   mode           : 00/11 stream, 01 ramp, 10 constant (sampled at fetch)
//   const_pair     : pair used in constant mode
//   up             : stream handshake (in_data / in_valid / in_ready)
//   afe_d, afe_sel : registered serial half word and phase select
//   pair_strobe    : high in the Q-phase cycle of each pair
//   underrun       : one-cycle pulse (I phase) when stream has no data
//   underrun_cnt   : saturating underrun count, clr_cnt clears it (wins)
module afe_iq_ser #(
  parameter int                       IQ_PAIR_WIDTH = 24,
  parameter logic [IQ_PAIR_WIDTH-1:0] IDLE_PAIR     = '0,
  parameter int                       CNT_WIDTH     = 16
) (
  input  logic                       clk_2x,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [IQ_PAIR_WIDTH-1:0]   const_pair,
  afe_iq_ser_if.slave                up,
  output logic [IQ_PAIR_WIDTH/2-1:0] afe_d,
  output logic                       afe_sel,
  output logic                       pair_strobe,
  output logic                       underrun,
  output logic [CNT_WIDTH-1:0]       underrun_cnt,
  input  logic                       clr_cnt
);
  localparam int W = IQ_PAIR_WIDTH;
  localparam int H = IQ_PAIR_WIDTH / 2;

  typedef enum logic [1:0] {IDLE = 2'd0, PH_I = 2'd1, PH_Q = 2'd2} state_t;

  state_t         state_q;
  logic [W-1:0]   pair_q, pair_d;
  logic [H-1:0]   ramp_q;
  logic [H-1:0]   afe_d_q;
  logic           afe_sel_q, strobe_q, und_q, und_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic           fetch, stream_m;

  // A new pair is pulled on any edge that leaves IDLE or PH_Q with enable.
  assign stream_m = (mode == 2'b00) || (mode == 2'b11);
  assign fetch    = enable && (state_q == IDLE || state_q == PH_Q);
  // Gated by reset so the handshake reads 0 while reset is held.
  assign up.in_ready = !reset && fetch && stream_m;

  // Pair chosen at the fetch edge; only consumed when fetch is true.
  always_comb begin
    pair_d = pair_q;
    und_d  = 1'b0;
    case (mode)
      2'b01:   pair_d = {~ramp_q, ramp_q};
      2'b10:   pair_d = const_pair;
      default: begin
        if (up.in_valid) pair_d = up.in_data;
        else begin
          pair_d = IDLE_PAIR;
          und_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_2x or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      ramp_q    <= '0;
      afe_d_q   <= '0;
      afe_sel_q <= 1'b0;
      strobe_q  <= 1'b0;
      und_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // Clear has priority over a same-edge increment.
      if (clr_cnt)
        cnt_q <= '0;
      else if (fetch && und_d && (cnt_q != {CNT_WIDTH{1'b1}}))
        cnt_q <= cnt_q + CNT_WIDTH'(1);

      case (state_q)
        PH_I: begin
          // Q half always follows, regardless of enable.
          state_q   <= PH_Q;
          afe_d_q   <= pair_q[W-1:H];
          afe_sel_q <= 1'b0;
          strobe_q  <= 1'b1;
          und_q     <= 1'b0;
        end
        default: begin
          if (enable) begin
            state_q   <= PH_I;
            pair_q    <= pair_d;
            afe_d_q   <= pair_d[H-1:0];
            afe_sel_q <= 1'b1;
            strobe_q  <= 1'b0;
            und_q     <= und_d;
            if (mode == 2'b01) ramp_q <= ramp_q + H'(1);
          end else begin
            state_q   <= IDLE;
            afe_d_q   <= '0;
            afe_sel_q <= 1'b0;
            strobe_q  <= 1'b0;
            und_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign afe_d        = afe_d_q;
  assign afe_sel      = afe_sel_q;
  assign pair_strobe  = strobe_q;
  assign underrun     = und_q;
  assign underrun_cnt = cnt_q;
endmodule

// File: doc/afe_iq_ser.md
Name: afe_iq_ser

Overview:
- Transmit-side counterpart of the AFE RX capture path. Accepts full IQ pairs over a ready/valid interface and serialises each pair onto a half-width bus with a phase select: low half with sel=1, then high half with sel=0.
- This is the same interleaved format the converter presents to our RX capture logic.
- Used as an on-FPGA AFE emulator for loopback and bring-up: it drives the RX capture path without the converter fitted.
- Also provides built-in ramp and constant pattern sources and underrun accounting.

Parameters:
- IQ_PAIR_WIDTH, 24, full IQ pair width in bits; must be even. Half width H = IQ_PAIR_WIDTH/2.
- IDLE_PAIR, 0, IQ_PAIR_WIDTH-bit pair emitted on underrun.
- CNT_WIDTH, 16, underrun counter width.

Ports:
- clk_2x  in  1  half-word clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  serialiser run enable.
- mode  in  2  source select: 00 stream, 01 ramp, 10 constant, 11 treated as stream.
- const_pair  in  IQ_PAIR_WIDTH  pair used in constant mode.
- in_data  in  IQ_PAIR_WIDTH  stream pair: {Q, I}, with I in the low H bits.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data on this edge.
- afe_d  out  H  serialised half word (registered).
- afe_sel  out  1  1 = I (low) half, 0 = Q (high) half (registered).
- pair_strobe  out  1  high for the Q-phase cycle of every emitted pair.
- underrun  out  1  one-cycle pulse per underrun.
- underrun_cnt  out  CNT_WIDTH  saturating underrun count.
- clr_cnt  in  1  synchronous clear of underrun_cnt.

Behaviour:
- Reset (async, immediate):
  - State is IDLE.
  - afe_d=0, afe_sel=0, pair_strobe=0, underrun=0, underrun_cnt=0, in_ready=0.
  - Ramp counter=0, pair register=0.
- States: IDLE, PH_I, PH_Q.
  - IDLE: afe_sel=0, afe_d=0. Goes to PH_I on the first edge where enable=1.
  - PH_I: afe_sel=1, afe_d=pair[H-1:0]. Always goes to PH_Q.
  - PH_Q: afe_sel=0, afe_d=pair[IQ_PAIR_WIDTH-1:H], pair_strobe=1. Goes to PH_I if enable=1, else to IDLE.
  - A started pair is always completed: deasserting enable during PH_I still emits PH_Q.
- Pair fetch:
  - Occurs on every edge entering PH_I.
  - mode is sampled at this edge only. Mode changes take effect at the next pair boundary.
- Stream mode:
  - in_ready = enable & (state==IDLE | state==PH_Q) & stream mode; combinational from registered state.
  - If in_valid=1 on the fetch edge: pair <= in_data.
  - If in_valid=0: pair <= IDLE_PAIR, underrun pulses for the PH_I cycle, and underrun_cnt increments, saturating at all-ones.
  - No data is ever dropped. in_valid on non-fetch edges is ignored and in_ready is 0 there.
- Ramp mode:
  - pair <= {~ramp, ramp}, then ramp <= ramp+1 (H bits, wraps at 2^H-1 to 0).
  - in_ready=0; never underruns.
  - Ramp is not reset by mode changes; it is reset only by reset.
- Constant mode: pair <= const_pair; in_ready=0.
- Latency: a pair accepted on edge N appears as its I half after edge N, and its Q half after edge N+1.
- Throughput: steady state is one pair per two clk_2x cycles; afe_sel toggles every cycle.
- clr_cnt:
  - Clears underrun_cnt on the edge where it is sampled.
  - Wins over a simultaneous increment: the counter reads 0 afterwards.
- Reset mid-pair: the outputs return to reset values asynchronously. No partial pair is resumed after reset release.

Test Plan:
- Reset, enable=1, stream, in_valid held high with pairs 0xABC123, 0x456DEF -> afe_sel sequence 1,0,1,0; afe_d 0x123, 0xABC, 0xDEF, 0x456; in_ready high only on IDLE/PH_Q cycles; pair_strobe on the 2nd and 4th cycles.
- Stream with in_valid low for one fetch edge -> that pair emits 0x000/0x000, underrun pulses once, underrun_cnt=1; the next valid pair is unaffected. With CNT_WIDTH=2, 5 underruns -> count holds at 3.
- Ramp mode from reset -> pairs I=0x000/Q=0xFFF, then I=0x001/Q=0xFFE. Force ramp to 0xFFF -> next I=0x000 (wrap).
- Deassert enable during PH_I -> Q half still emitted, then IDLE with afe_sel=0 and afe_d=0. Re-enable -> the first cycle is PH_I.
- Switch mode stream->constant (const_pair=0x5A5A5A) mid-pair -> the current pair completes from the stream; the next pair is 0xA5A/0x5A5; in_ready drops at the fetch edge.
- Assert reset during PH_Q -> all outputs 0 immediately. clr_cnt together with an underrun on the same edge -> underrun_cnt=0.
